// File: rtl/time_unit_counter_if.sv
// Control/status bundle between the clock datapath and one time-unit counter.
// Master drives tick/enable/direction/load; slave (the counter) returns count and flags.
// Purely combinational wiring; no storage, no flow control.
interface time_unit_counter_if #(
  parameter int WIDTH = 6
);
  logic             en;
  logic             tick_in;
  logic             dir;
  logic             load_en;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             carry_out;
  logic             load_err;

  modport master (
    output en, tick_in, dir, load_en, load_val,
    input  cnt, carry_out, load_err
  );

  modport slave (
    input  en, tick_in, dir, load_en, load_val,
    output cnt, carry_out, load_err
  );
endinterface

// File: rtl/time_unit_counter.sv
// Modulo-MODULUS up/down counter advanced on tick_in rising edges, with checked load.
// Latency: cnt/carry_out update on the clk edge that samples the tick rise or load.
// No backpressure: a tick rise coinciding with a load is dropped, never queued.
module time_unit_counter #(
  parameter int MODULUS   = 60,
  parameter int WIDTH     = 6,
  parameter int RESET_VAL = 0
) (
  input  logic                 clk,
  input  logic                 resett,
  time_unit_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             tick_q;
  logic             tick_rise;

  // Rising-edge detect on tick_in; the history register tracks tick_in every
  // cycle so a level held while disabled or loading never counts later.
  assign tick_rise = bus.tick_in & ~tick_q;

  // Next-state: load beats counting; carry is a pulse only on a counting wrap.
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    err_d   = err_q;
    if (bus.load_en) begin
      if (bus.load_val > MAX_VAL) begin
        err_d = 1'b1;
      end else begin
        cnt_d = bus.load_val;
        err_d = 1'b0;
      end
    end else if (bus.en && tick_rise) begin
      if (!bus.dir) begin
        if (cnt_q == MAX_VAL) begin
          cnt_d   = ZERO;
          carry_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == ZERO) begin
          cnt_d   = MAX_VAL;
          carry_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  // Tick history register, cleared by reset so a level held through reset counts once.
  always_ff @(posedge clk or negedge resett) begin
    if (!resett) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= bus.tick_in;
    end
  end

  // Count, carry pulse and sticky load error registers.
  always_ff @(posedge clk or negedge resett) begin
    if (!resett) begin
      cnt_q   <= RST_VAL;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign bus.cnt       = cnt_q;
  assign bus.carry_out = carry_q;
  assign bus.load_err  = err_q;

endmodule

// File: tb/tb_time_unit_counter.sv
// Self-checking bench: four counters (60 up/down, 24 with reset value 23, and a
// two-stage 60/60 cascade) checked every cycle against an integer modulo model,
// plus directed sequences with hand-computed expectations.
module tb_time_unit_counter;

  logic clk;
  logic resett;
  bit   chk_on;
  int   checks;
  int   errors;

  time_unit_counter_if #(.WIDTH(6)) a_if ();
  time_unit_counter_if #(.WIDTH(5)) b_if ();
  time_unit_counter_if #(.WIDTH(6)) c0_if ();
  time_unit_counter_if #(.WIDTH(6)) c1_if ();

  time_unit_counter #(.MODULUS(60), .WIDTH(6), .RESET_VAL(0))  u_a  (.clk(clk), .resett(resett), .bus(a_if.slave));
  time_unit_counter #(.MODULUS(24), .WIDTH(5), .RESET_VAL(23)) u_b  (.clk(clk), .resett(resett), .bus(b_if.slave));
  time_unit_counter #(.MODULUS(60), .WIDTH(6), .RESET_VAL(0))  u_c0 (.clk(clk), .resett(resett), .bus(c0_if.slave));
  time_unit_counter #(.MODULUS(60), .WIDTH(6), .RESET_VAL(0))  u_c1 (.clk(clk), .resett(resett), .bus(c1_if.slave));

  // Cascade: stage 0 carry is stage 1 tick.
  assign c1_if.tick_in = c0_if.carry_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int MODS [4] = '{60, 24, 60, 60};
  localparam int RSTS [4] = '{0, 23, 0, 0};
  int m_cnt [4];
  bit m_car [4];
  bit m_err [4];
  bit m_tp  [4];

  task automatic step(input int m, input int c, input bit tp, input bit en,
                      input bit tick, input bit dir, input bit ld, input int lv,
                      input bit err, output int nc, output bit nk, output bit ne);
    nc = c; nk = 1'b0; ne = err;
    if (ld) begin
      if (lv >= m) ne = 1'b1;
      else begin nc = lv; ne = 1'b0; end
    end else if (en && tick && !tp) begin
      if (!dir) begin nc = (c + 1) % m;     nk = (c == m - 1); end
      else      begin nc = (c + m - 1) % m; nk = (c == 0);     end
    end
  endtask

  always @(posedge clk or negedge resett) begin
    int nc;
    bit nk, ne;
    if (!resett) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] <= RSTS[i]; m_car[i] <= 1'b0; m_err[i] <= 1'b0; m_tp[i] <= 1'b0;
      end
    end else begin
      step(MODS[0], m_cnt[0], m_tp[0], a_if.en, a_if.tick_in, a_if.dir, a_if.load_en,
           int'(a_if.load_val), m_err[0], nc, nk, ne);
      m_cnt[0] <= nc; m_car[0] <= nk; m_err[0] <= ne; m_tp[0] <= a_if.tick_in;
      step(MODS[1], m_cnt[1], m_tp[1], b_if.en, b_if.tick_in, b_if.dir, b_if.load_en,
           int'(b_if.load_val), m_err[1], nc, nk, ne);
      m_cnt[1] <= nc; m_car[1] <= nk; m_err[1] <= ne; m_tp[1] <= b_if.tick_in;
      step(MODS[2], m_cnt[2], m_tp[2], c0_if.en, c0_if.tick_in, c0_if.dir, c0_if.load_en,
           int'(c0_if.load_val), m_err[2], nc, nk, ne);
      m_cnt[2] <= nc; m_car[2] <= nk; m_err[2] <= ne; m_tp[2] <= c0_if.tick_in;
      step(MODS[3], m_cnt[3], m_tp[3], c1_if.en, m_car[2], c1_if.dir, c1_if.load_en,
           int'(c1_if.load_val), m_err[3], nc, nk, ne);
      m_cnt[3] <= nc; m_car[3] <= nk; m_err[3] <= ne; m_tp[3] <= m_car[2];
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a.cnt",   int'(a_if.cnt),        m_cnt[0]);
      chk("a.carry", int'(a_if.carry_out),  int'(m_car[0]));
      chk("a.err",   int'(a_if.load_err),   int'(m_err[0]));
      chk("b.cnt",   int'(b_if.cnt),        m_cnt[1]);
      chk("b.carry", int'(b_if.carry_out),  int'(m_car[1]));
      chk("b.err",   int'(b_if.load_err),   int'(m_err[1]));
      chk("c0.cnt",  int'(c0_if.cnt),       m_cnt[2]);
      chk("c0.carry",int'(c0_if.carry_out), int'(m_car[2]));
      chk("c0.err",  int'(c0_if.load_err),  int'(m_err[2]));
      chk("c1.cnt",  int'(c1_if.cnt),       m_cnt[3]);
      chk("c1.carry",int'(c1_if.carry_out), int'(m_car[3]));
      chk("c1.err",  int'(c1_if.load_err),  int'(m_err[3]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_tick(input int s, input bit v);
    case (s)
      0: a_if.tick_in = v;
      1: b_if.tick_in = v;
      2: c0_if.tick_in = v;
      default: ;
    endcase
  endtask

  task automatic set_load(input int s, input bit on, input int v);
    case (s)
      0: begin a_if.load_en  = on; a_if.load_val  = 6'(v); end
      1: begin b_if.load_en  = on; b_if.load_val  = 5'(v); end
      2: begin c0_if.load_en = on; c0_if.load_val = 6'(v); end
      default: begin c1_if.load_en = on; c1_if.load_val = 6'(v); end
    endcase
  endtask

  task automatic pulse(input int s);
    cyc(); set_tick(s, 1'b1);
    cyc(); set_tick(s, 1'b0);
  endtask

  task automatic do_load(input int s, input int v);
    cyc(); set_load(s, 1'b1, v);
    cyc(); set_load(s, 1'b0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks = 0; errors = 0; chk_on = 1'b0;
    resett = 1'b0;
    a_if.en = 1'b1;  a_if.tick_in = 1'b0;  a_if.dir = 1'b0;  a_if.load_en = 1'b0;  a_if.load_val = '0;
    b_if.en = 1'b1;  b_if.tick_in = 1'b0;  b_if.dir = 1'b0;  b_if.load_en = 1'b0;  b_if.load_val = '0;
    c0_if.en = 1'b1; c0_if.tick_in = 1'b0; c0_if.dir = 1'b0; c0_if.load_en = 1'b0; c0_if.load_val = '0;
    c1_if.en = 1'b1; c1_if.dir = 1'b0; c1_if.load_en = 1'b0; c1_if.load_val = '0;

    repeat (2) cyc();
    chk_on = 1'b1;
    chk("rst a.cnt", int'(a_if.cnt), 0);
    chk("rst b.cnt", int'(b_if.cnt), 23);
    chk("rst a.carry", int'(a_if.carry_out), 0);
    resett = 1'b1;

    // Reset/hold: ten idle cycles leave everything at reset values.
    repeat (10) cyc();
    chk("hold a.cnt", int'(a_if.cnt), 0);
    chk("hold a.err", int'(a_if.load_err), 0);

    // Up wrap 58 -> 59 -> 0 with a single carry coincident with 0.
    do_load(0, 58);
    pulse(0);
    chk("upwrap cnt59", int'(a_if.cnt), 59);
    chk("upwrap carry0", int'(a_if.carry_out), 0);
    pulse(0);
    chk("upwrap cnt0", int'(a_if.cnt), 0);
    chk("upwrap carry1", int'(a_if.carry_out), 1);
    cyc();
    chk("upwrap carry_end", int'(a_if.carry_out), 0);

    // Level tick held 5 cycles counts once.
    do_load(0, 10);
    cyc(); set_tick(0, 1'b1);
    repeat (5) cyc();
    set_tick(0, 1'b0);
    cyc();
    chk("level cnt", int'(a_if.cnt), 11);

    // Down wrap on modulus 24: 1 -> 0 -> 23.
    b_if.dir = 1'b1;
    do_load(1, 1);
    pulse(1);
    chk("down cnt0", int'(b_if.cnt), 0);
    chk("down carry0", int'(b_if.carry_out), 0);
    pulse(1);
    chk("down cnt23", int'(b_if.cnt), 23);
    chk("down carry1", int'(b_if.carry_out), 1);

    // Range-checked load.
    do_load(0, 60);
    chk("badload cnt", int'(a_if.cnt), 11);
    chk("badload err", int'(a_if.load_err), 1);
    do_load(0, 30);
    chk("goodload cnt", int'(a_if.cnt), 30);
    chk("goodload err", int'(a_if.load_err), 0);

    // Cascade with tick/load collision on stage 0.
    do_load(2, 59);
    do_load(3, 5);
    pulse(2);
    chk("casc c0 wrap", int'(c0_if.cnt), 0);
    chk("casc c0 carry", int'(c0_if.carry_out), 1);
    cyc(); set_tick(2, 1'b1); set_load(2, 1'b1, 7);
    cyc(); set_tick(2, 1'b0); set_load(2, 1'b0, 0);
    chk("coll c0", int'(c0_if.cnt), 7);
    chk("coll c0 carry", int'(c0_if.carry_out), 0);
    chk("coll c1", int'(c1_if.cnt), 6);
    cyc();
    chk("coll c1 hold", int'(c1_if.cnt), 6);
    chk("coll c1 carry", int'(c1_if.carry_out), 0);

    // Mid-count asynchronous reset, with A's tick held high across it.
    pulse(2);
    pulse(2);
    cyc();
    set_tick(0, 1'b1);
    resett = 1'b0;
    #1;
    chk("midrst c0", int'(c0_if.cnt), 0);
    chk("midrst c1", int'(c1_if.cnt), 0);
    chk("midrst a", int'(a_if.cnt), 0);
    chk("midrst b", int'(b_if.cnt), 23);
    cyc(); cyc();
    resett = 1'b1;
    cyc();
    chk("held tick counts", int'(a_if.cnt), 1);
    repeat (3) cyc();
    chk("held tick once", int'(a_if.cnt), 1);
    set_tick(0, 1'b0);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      a_if.en = ($urandom_range(0, 7) != 0);
      a_if.tick_in = 1'($urandom_range(0, 1));
      a_if.dir = 1'($urandom_range(0, 1));
      set_load(0, ($urandom_range(0, 15) == 0), int'($urandom_range(0, 63)));
      b_if.en = ($urandom_range(0, 7) != 0);
      b_if.tick_in = 1'($urandom_range(0, 1));
      b_if.dir = 1'($urandom_range(0, 1));
      set_load(1, ($urandom_range(0, 15) == 0), int'($urandom_range(0, 31)));
      c0_if.en = ($urandom_range(0, 15) != 0);
      c0_if.tick_in = 1'($urandom_range(0, 1));
      c0_if.dir = ($urandom_range(0, 7) == 0);
      set_load(2, ($urandom_range(0, 31) == 0), int'($urandom_range(0, 63)));
      set_load(3, ($urandom_range(0, 63) == 0), int'($urandom_range(0, 63)));
    end

    cyc();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_unit_counter.md
# time_unit_counter

Parametrised modulo-N time-unit counter for the clock datapath: seconds, minutes, hours and similar digits, chained through carry pulses. It advances once per rising edge of its tick input and counts up or down. It loads an arbitrary value from the UART control path with a range check, and emits a one-cycle carry/borrow pulse on wrap so instances cascade directly.

## Interface
Parameters:
- MODULUS, 60: count range is 0..MODULUS-1; MODULUS >= 2.
- WIDTH, 6: counter width; must satisfy 2^WIDTH >= MODULUS.
- RESET_VAL, 0: value of cnt after reset; must be < MODULUS.

Ports:
- clk  in  1  system clock; all logic on posedge.
- resett  in  1  asynchronous, active-low reset.
- en  in  1  count enable; ticks ignored while low.
- tick_in  in  1  advance request (level or pulse); counted on its rising edge only.
- dir  in  1  0 = count up, 1 = count down; sampled on the counting edge.
- load_en  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- cnt  out  WIDTH  current count, registered.
- carry_out  out  1  one-cycle pulse on wrap (up: MODULUS-1→0; down: 0→MODULUS-1).
- load_err  out  1  sticky; set by an out-of-range load attempt.

## Operation
- Edge detect: register tick_d <= tick_in every cycle regardless of en, load_en or dir. tick_rise = tick_in & ~tick_d.
- Priority, highest first:
  - reset
  - load_en
  - counting on (en & tick_rise)
  - hold
- Load, load_val < MODULUS: cnt <= load_val, load_err <= 0.
- Load, load_val >= MODULUS: cnt unchanged, load_err <= 1.
- A tick_rise in the same cycle as load_en is dropped; it is not deferred.
- Count up: if cnt == MODULUS-1 then cnt <= 0 and carry_out <= 1, else cnt <= cnt+1.
- Count down: if cnt == 0 then cnt <= MODULUS-1 and carry_out <= 1, else cnt <= cnt-1.
- carry_out is 0 in every cycle without a wrap. Load never produces carry_out, including a load of 0 or MODULUS-1.
- Arithmetic is WIDTH bits. Comparisons use the full WIDTH. cnt never leaves 0..MODULUS-1.
- en low: cnt holds and tick_d still tracks tick_in. Raising en while tick_in is already high does not count.
- State: cnt, tick_d, carry_out, load_err. There is no other FSM; the behaviour is the datapath above.
- Cascade: carry_out of stage k drives tick_in of stage k+1, with that stage's en tied high.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release by the system):
  - cnt = RESET_VAL
  - carry_out = 0
  - load_err = 0
  - tick_d = 0
- After reset release, a tick_in held high through reset counts once on the first clk edge.
- Latency: when tick_in rises before edge k, cnt and carry_out update at edge k (visible in cycle k+1). Per cascade stage, add one cycle.
- tick_in high for N cycles counts exactly once. Back-to-back counting needs tick_in low for at least one sampled cycle between highs.
- Load takes effect at the edge where load_en is high. load_err updates at the same edge.
- dir change takes effect at the next counting edge. There is no pipeline hazard.
- Reset asserted mid-operation clears everything immediately. A carry_out pulse in flight is truncated.

## Test plan
- Reset/hold, MODULUS=60, RESET_VAL=0: release resett, hold tick_in=0 for 10 cycles → cnt=0, carry_out=0, load_err=0 throughout.
- Up wrap, MODULUS=60: load 58, then 2 tick pulses → cnt 59, then 0. carry_out high for exactly 1 cycle, coincident with cnt=0.
- Level tick, MODULUS=60: tick_in held high for 5 cycles, dir=0, from cnt=10 → cnt=11 only, single increment.
- Down wrap, MODULUS=24, WIDTH=5: dir=1, load 1, 2 ticks → cnt 0, then 23. carry_out pulses once, on the 0→23 transition.
- Load check, MODULUS=60: load 60 → cnt unchanged, load_err=1. Then load 30 → cnt=30, load_err=0.
- Collision, two-stage cascade (60, 60): stage0=59, stage1=5, tick then load stage0 with 7 in the same cycle as the next tick_rise → stage0=0 and stage1=6 after the first tick. At the collision cycle stage0=7, and no extra carry propagates. Also assert resett mid-count → both stages reset immediately.
